// File: rtl/wb_if.sv
// Wishbone B3 classic bus bundle. Widths are the maximum bus widths; a
// master narrower than the bus zero-extends its outputs and ignores the
// upper read-data bits.
interface wb_if #(
  parameter int WB_ADR_MAX_WIDTH = 64,
  parameter int WB_DAT_MAX_WIDTH = 64
);
  logic                          cyc;
  logic                          stb;
  logic                          we;
  logic [WB_ADR_MAX_WIDTH-1:0]   adr;
  logic [WB_DAT_MAX_WIDTH/8-1:0] sel;
  logic [WB_DAT_MAX_WIDTH-1:0]   dat_m2s;
  logic [WB_DAT_MAX_WIDTH-1:0]   dat_s2m;
  logic                          ack;
  logic                          err;
  logic                          rty;
  logic [2:0]                    cti;
  logic [1:0]                    bte;

  modport mst (
    output cyc, stb, we, adr, sel, dat_m2s, cti, bte,
    input  dat_s2m, ack, err, rty
  );

  modport slv (
    input  cyc, stb, we, adr, sel, dat_m2s, cti, bte,
    output dat_s2m, ack, err, rty
  );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone B3 classic single-transfer master. Turns each command on a
// valid/ready stream into one bus cycle (with bounded retry on rty and an
// optional hang timeout) and returns the outcome on a valid/ready response
// stream. Strictly one transaction in flight.
module wb_cmd_master #(
  parameter int DAT_W     = 32,
  parameter int ADR_W     = 32,
  parameter int MAX_RETRY = 3,
  parameter int BACKOFF   = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_we,
  input  logic [ADR_W-1:0]   cmd_adr,
  input  logic [DAT_W-1:0]   cmd_dat,
  input  logic [DAT_W/8-1:0] cmd_sel,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DAT_W-1:0]   rsp_dat,
  output logic [1:0]         rsp_status,
  wb_if.mst                  wb
);

  localparam int SEL_W   = DAT_W / 8;
  localparam int ADR_MAX = $bits(wb.adr);
  localparam int DAT_MAX = $bits(wb.dat_m2s);
  localparam int SEL_MAX = $bits(wb.sel);

  // Counter widths, never narrower than one bit.
  localparam int RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TO_W = (TIMEOUT > 0)   ? $clog2(TIMEOUT + 1)   : 1;
  localparam int BO_W = (BACKOFF > 1)   ? $clog2(BACKOFF + 1)   : 1;

  localparam logic [RT_W-1:0] RT_MAX  = RT_W'(MAX_RETRY);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);
  localparam logic [BO_W-1:0] BO_LAST = BO_W'(BACKOFF - 1);

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_ERR     = 2'd1;
  localparam logic [1:0] ST_RTY     = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CYCLE   = 2'd1,
    S_BACKOFF = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t           state;
  logic             bus_cyc;
  logic             bus_we;
  logic [ADR_W-1:0] bus_adr;
  logic [DAT_W-1:0] bus_dat;
  logic [SEL_W-1:0] bus_sel;
  logic [RT_W-1:0]  retry_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [BO_W-1:0]  bo_cnt;

  logic             finish;
  logic [1:0]       fin_status;
  logic [DAT_W-1:0] fin_dat;
  logic             retry_now;
  logic [TO_W-1:0]  to_next;
  logic             unused_s2m;

  // Bus drive: the bus registers double as the latched command, so adr/we/
  // sel/dat stay stable through the cycle and across backoff re-issues.
  assign wb.cyc     = bus_cyc;
  assign wb.stb     = bus_cyc;
  assign wb.we      = bus_we;
  assign wb.adr     = ADR_MAX'(bus_adr);
  assign wb.dat_m2s = DAT_MAX'(bus_dat);
  assign wb.sel     = SEL_MAX'(bus_sel);
  assign wb.cti     = 3'b000;
  assign wb.bte     = 2'b00;
  assign unused_s2m = ^wb.dat_s2m;

  // Decode the slave response while in CYCLE (err > ack > rty > timeout).
  always_comb begin
    finish     = 1'b0;
    fin_status = ST_OK;
    fin_dat    = {DAT_W{1'b0}};
    retry_now  = 1'b0;
    to_next    = to_cnt;
    if (state == S_CYCLE) begin
      if (wb.err) begin
        finish     = 1'b1;
        fin_status = ST_ERR;
      end else if (wb.ack) begin
        finish     = 1'b1;
        fin_status = ST_OK;
        fin_dat    = bus_we ? {DAT_W{1'b0}} : wb.dat_s2m[DAT_W-1:0];
      end else if (wb.rty) begin
        if (retry_cnt < RT_MAX) begin
          retry_now = 1'b1;
        end else begin
          finish     = 1'b1;
          fin_status = ST_RTY;
        end
      end else if (TIMEOUT != 0) begin
        to_next = to_cnt + TO_W'(1);
        if (to_next == TO_MAX) begin
          finish     = 1'b1;
          fin_status = ST_TIMEOUT;
        end else begin
          finish = 1'b0;
        end
      end else begin
        to_next = to_cnt;
      end
    end else begin
      finish = 1'b0;
    end
  end

  // Transaction FSM with registered bus and stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_dat    <= {DAT_W{1'b0}};
      rsp_status <= ST_OK;
      bus_cyc    <= 1'b0;
      bus_we     <= 1'b0;
      bus_adr    <= {ADR_W{1'b0}};
      bus_dat    <= {DAT_W{1'b0}};
      bus_sel    <= {SEL_W{1'b0}};
      retry_cnt  <= {RT_W{1'b0}};
      to_cnt     <= {TO_W{1'b0}};
      bo_cnt     <= {BO_W{1'b0}};
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            bus_cyc   <= 1'b1;
            bus_we    <= cmd_we;
            bus_adr   <= cmd_adr;
            bus_dat   <= cmd_dat;
            bus_sel   <= cmd_sel;
            retry_cnt <= {RT_W{1'b0}};
            to_cnt    <= {TO_W{1'b0}};
            state     <= S_CYCLE;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        S_CYCLE: begin
          if (finish) begin
            bus_cyc    <= 1'b0;
            bus_we     <= 1'b0;
            bus_adr    <= {ADR_W{1'b0}};
            bus_dat    <= {DAT_W{1'b0}};
            bus_sel    <= {SEL_W{1'b0}};
            rsp_valid  <= 1'b1;
            rsp_status <= fin_status;
            rsp_dat    <= fin_dat;
            state      <= S_RESP;
          end else if (retry_now) begin
            bus_cyc   <= 1'b0;
            retry_cnt <= retry_cnt + RT_W'(1);
            bo_cnt    <= {BO_W{1'b0}};
            state     <= S_BACKOFF;
          end else begin
            to_cnt <= to_next;
          end
        end
        S_BACKOFF: begin
          if (bo_cnt == BO_LAST) begin
            bus_cyc <= 1'b1;
            to_cnt  <= {TO_W{1'b0}};
            state   <= S_CYCLE;
          end else begin
            bo_cnt <= bo_cnt + BO_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            rsp_dat    <= {DAT_W{1'b0}};
            rsp_status <= ST_OK;
            cmd_ready  <= 1'b1;
            state      <= S_IDLE;
          end else begin
            rsp_valid <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          bus_cyc   <= 1'b0;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: zero-wait write, wait-state read, retry
// exhaustion, retry recovery, timeout, err/ack priority with response
// back-pressure, and reset in the middle of a cycle.
module tb_wb_cmd_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;

  int errors = 0;
  int checks = 0;

  wb_if bus ();

  wb_cmd_master #(
    .DAT_W(32), .ADR_W(32), .MAX_RETRY(3), .BACKOFF(4), .TIMEOUT(255)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_status(rsp_status), .wb(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    tick();
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 32'h0; cmd_dat = 32'h0; cmd_sel = 4'h0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %0b want 0", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %0b want 0", rsp_valid); end
    checks++; if ({bus.cyc, bus.stb, bus.we} !== 3'b000) begin errors++; $display("FAIL rst_cyc_stb_we: got %b want 000", {bus.cyc, bus.stb, bus.we}); end
    checks++; if (bus.adr !== 64'h0 || bus.dat_m2s !== 64'h0 || bus.sel !== 8'h0) begin errors++; $display("FAIL rst_adr_dat_sel: got %h %h %h want 0 0 0", bus.adr, bus.dat_m2s, bus.sel); end
    checks++; if (rsp_dat !== 32'h0 || rsp_status !== 2'd0) begin errors++; $display("FAIL rst_rsp: got %h/%0d want 0/0", rsp_dat, rsp_status); end
    checks++; if (bus.cti !== 3'b000 || bus.bte !== 2'b00) begin errors++; $display("FAIL rst_cti_bte: got %b/%b want 000/00", bus.cti, bus.bte); end
    rst = 1'b0;
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_rst_cmd_ready: got %0b want 1", cmd_ready); end
  endtask

  task automatic test_write_zero_wait();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %0b want 1", cmd_ready); end
    issue(1'b1, 32'h10, 32'hA5A5_0001, 4'hF);
    checks++; if ({bus.cyc, bus.stb, bus.we} !== 3'b111) begin errors++; $display("FAIL wr_cyc_stb_we: got %b want 111", {bus.cyc, bus.stb, bus.we}); end
    checks++; if (bus.adr !== 64'h10) begin errors++; $display("FAIL wr_adr: got %h want 10", bus.adr); end
    checks++; if (bus.dat_m2s !== 64'h0000_0000_A5A5_0001) begin errors++; $display("FAIL wr_dat: got %h want a5a50001", bus.dat_m2s); end
    checks++; if (bus.sel !== 8'h0F) begin errors++; $display("FAIL wr_sel: got %h want 0f", bus.sel); end
    checks++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_busy: got ready=%0b valid=%0b want 0 0", cmd_ready, rsp_valid); end
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    checks++; if (bus.cyc !== 1'b0 || bus.adr !== 64'h0) begin errors++; $display("FAIL wr_cyc_drop: got cyc=%0b adr=%h want 0 0", bus.cyc, bus.adr); end
    checks++; if (rsp_valid !== 1'b1 || rsp_status !== 2'd0 || rsp_dat !== 32'h0) begin errors++; $display("FAIL wr_rsp: got v=%0b st=%0d d=%h want 1 0 0", rsp_valid, rsp_status, rsp_dat); end
    consume();
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_done: got v=%0b ready=%0b want 0 1", rsp_valid, cmd_ready); end
  endtask

  task automatic test_read_wait();
    int cyc_len = 0;
    issue(1'b0, 32'h20, 32'h0, 4'hF);
    checks++; if (bus.we !== 1'b0 || bus.adr !== 64'h20) begin errors++; $display("FAIL rd_we_adr: got %0b %h want 0 20", bus.we, bus.adr); end
    for (int i = 0; i < 20 && rsp_valid !== 1'b1; i++) begin
      if (bus.cyc === 1'b1) cyc_len++;
      if (bus.cyc === 1'b1 && cyc_len == 4) begin
        bus.ack = 1'b1;
        bus.dat_s2m = 64'hFFFF_0000_DEAD_BEEF;
      end
      tick();
    end
    bus.ack = 1'b0;
    bus.dat_s2m = 64'h0;
    checks++; if (cyc_len != 4) begin errors++; $display("FAIL rd_cyc_len: got %0d want 4", cyc_len); end
    checks++; if (rsp_valid !== 1'b1 || rsp_dat !== 32'hDEAD_BEEF || rsp_status !== 2'd0) begin errors++; $display("FAIL rd_rsp: got v=%0b d=%h st=%0d want 1 deadbeef 0", rsp_valid, rsp_dat, rsp_status); end
    consume();
  endtask

  task automatic test_retry_exhaust();
    int pulses = 0, hi_len = 0, lo_len = 0, bad_hi = 0, bad_lo = 0;
    logic prev = 1'b0;
    bus.rty = 1'b1;
    issue(1'b0, 32'h40, 32'h0, 4'hF);
    for (int i = 0; i < 200 && rsp_valid !== 1'b1; i++) begin
      if (bus.cyc === 1'b1) begin
        if (!prev) begin
          pulses++;
          if (pulses > 1 && lo_len != 4) bad_lo++;
          hi_len = 0;
        end
        hi_len++;
      end else begin
        if (prev) begin
          if (hi_len != 1) bad_hi++;
          lo_len = 0;
        end
        lo_len++;
      end
      prev = bus.cyc;
      tick();
    end
    bus.rty = 1'b0;
    checks++; if (pulses != 4) begin errors++; $display("FAIL rty_pulses: got %0d want 4", pulses); end
    checks++; if (bad_lo != 0) begin errors++; $display("FAIL rty_gaps: got %0d bad gaps want 0", bad_lo); end
    checks++; if (bad_hi != 0 || hi_len != 1) begin errors++; $display("FAIL rty_width: got %0d bad, last %0d want 0, 1", bad_hi, hi_len); end
    checks++; if (rsp_valid !== 1'b1 || rsp_status !== 2'd2 || rsp_dat !== 32'h0) begin errors++; $display("FAIL rty_rsp: got v=%0b st=%0d d=%h want 1 2 0", rsp_valid, rsp_status, rsp_dat); end
    consume();
  endtask

  task automatic test_retry_then_ack();
    int pulses = 0;
    logic prev = 1'b0;
    issue(1'b0, 32'h44, 32'h0, 4'h3);
    for (int i = 0; i < 50 && rsp_valid !== 1'b1; i++) begin
      if (bus.cyc === 1'b1 && !prev) pulses++;
      if (bus.cyc === 1'b1 && pulses == 1) bus.rty = 1'b1;
      if (bus.cyc === 1'b1 && pulses == 2) begin
        bus.rty = 1'b0;
        bus.ack = 1'b1;
        bus.dat_s2m = 64'h0000_0000_CAFE_0042;
      end
      prev = bus.cyc;
      tick();
    end
    bus.rty = 1'b0; bus.ack = 1'b0; bus.dat_s2m = 64'h0;
    checks++; if (pulses != 2) begin errors++; $display("FAIL rty_ack_pulses: got %0d want 2", pulses); end
    checks++; if (rsp_valid !== 1'b1 || rsp_status !== 2'd0 || rsp_dat !== 32'hCAFE_0042) begin errors++; $display("FAIL rty_ack_rsp: got v=%0b st=%0d d=%h want 1 0 cafe0042", rsp_valid, rsp_status, rsp_dat); end
    consume();
  endtask

  task automatic test_timeout_back_to_back();
    int cyc_len = 0;
    issue(1'b0, 32'h50, 32'h0, 4'hF);
    for (int i = 0; i < 400 && rsp_valid !== 1'b1; i++) begin
      if (bus.cyc === 1'b1) cyc_len++;
      tick();
    end
    checks++; if (cyc_len != 255) begin errors++; $display("FAIL to_cyc_len: got %0d want 255", cyc_len); end
    checks++; if (rsp_valid !== 1'b1 || rsp_status !== 2'd3 || rsp_dat !== 32'h0) begin errors++; $display("FAIL to_rsp: got v=%0b st=%0d d=%h want 1 3 0", rsp_valid, rsp_status, rsp_dat); end
    consume();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %0b want 1", cmd_ready); end
    issue(1'b0, 32'h54, 32'h0, 4'hF);
    bus.ack = 1'b1;
    bus.dat_s2m = 64'h0000_0000_1234_5678;
    tick();
    bus.ack = 1'b0; bus.dat_s2m = 64'h0;
    checks++; if (rsp_valid !== 1'b1 || rsp_status !== 2'd0 || rsp_dat !== 32'h1234_5678) begin errors++; $display("FAIL b2b_rsp: got v=%0b st=%0d d=%h want 1 0 12345678", rsp_valid, rsp_status, rsp_dat); end
    consume();
  endtask

  task automatic test_err_hold();
    int hold_bad = 0;
    issue(1'b0, 32'h60, 32'h0, 4'hF);
    bus.err = 1'b1; bus.ack = 1'b1;
    bus.dat_s2m = 64'h0000_0000_5555_AAAA;
    tick();
    bus.err = 1'b0; bus.ack = 1'b0; bus.dat_s2m = 64'h0;
    checks++; if (rsp_valid !== 1'b1 || rsp_status !== 2'd1 || rsp_dat !== 32'h0) begin errors++; $display("FAIL err_rsp: got v=%0b st=%0d d=%h want 1 1 0", rsp_valid, rsp_status, rsp_dat); end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_status !== 2'd1 || rsp_dat !== 32'h0 || cmd_ready !== 1'b0 || bus.cyc !== 1'b0) hold_bad++;
    end
    checks++; if (hold_bad != 0) begin errors++; $display("FAIL err_hold: got %0d unstable cycles want 0", hold_bad); end
    consume();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL err_release: got %0b want 0", rsp_valid); end
  endtask

  task automatic test_reset_mid_cycle();
    issue(1'b0, 32'h70, 32'h0, 4'hF);
    checks++; if (bus.cyc !== 1'b1) begin errors++; $display("FAIL mrst_cyc_up: got %0b want 1", bus.cyc); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.cyc !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL mrst_drop: got cyc=%0b v=%0b ready=%0b want 0 0 0", bus.cyc, rsp_valid, cmd_ready); end
    tick();
    checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || bus.cyc !== 1'b0) begin errors++; $display("FAIL mrst_idle: got ready=%0b v=%0b cyc=%0b want 1 0 0", cmd_ready, rsp_valid, bus.cyc); end
    issue(1'b1, 32'h74, 32'h0000_005A, 4'h3);
    checks++; if (bus.cyc !== 1'b1 || bus.adr !== 64'h74 || bus.sel !== 8'h03 || bus.dat_m2s !== 64'h5A) begin errors++; $display("FAIL mrst_next_bus: got cyc=%0b adr=%h sel=%h dat=%h want 1 74 03 5a", bus.cyc, bus.adr, bus.sel, bus.dat_m2s); end
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_status !== 2'd0 || rsp_dat !== 32'h0) begin errors++; $display("FAIL mrst_next_rsp: got v=%0b st=%0d d=%h want 1 0 0", rsp_valid, rsp_status, rsp_dat); end
    consume();
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 32'h0; cmd_dat = 32'h0;
    cmd_sel = 4'h0; rsp_ready = 1'b0;
    bus.ack = 1'b0; bus.err = 1'b0; bus.rty = 1'b0; bus.dat_s2m = 64'h0;
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_retry_exhaust();
    test_retry_then_ack();
    test_timeout_back_to_back();
    test_err_hold();
    test_reset_mid_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_cmd_master.md
# wb_cmd_master

Wishbone B3 classic single-transfer master. It sits directly upstream of the team's `wb_if` interface and drives its `mst` modport. It converts a valid/ready command stream (address, write data, byte select, direction) into one Wishbone cycle per command, and returns read data plus a completion status on a valid/ready response stream. It handles slave `ack`/`err`/`rty` responses, retries up to a bounded count, and aborts hung cycles with a timeout.

## Interface
Parameters:
- `DAT_W`, 32: data width; must be ≤ `WB_DAT_MAX_WIDTH` and a multiple of 8.
- `ADR_W`, 32: address width; must be ≤ `WB_ADR_MAX_WIDTH`.
- `MAX_RETRY`, 3: number of re-issues allowed after `rty`; 0 means no retry.
- `BACKOFF`, 4: idle cycles between a `rty` and the re-issue; must be ≥ 1.
- `TIMEOUT`, 255: cycles with `cyc` high and no response before abort; 0 disables the timeout.

Ports:
- `clk`, in, 1: the only clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: command accepted when high together with `cmd_valid`.
- `cmd_we`, in, 1: 1 = write, 0 = read.
- `cmd_adr`, in, `ADR_W`: byte address.
- `cmd_dat`, in, `DAT_W`: write data.
- `cmd_sel`, in, `DAT_W/8`: byte selects.
- `rsp_valid`, out, 1: response present.
- `rsp_ready`, in, 1: response consumed.
- `rsp_dat`, out, `DAT_W`: read data; 0 for writes and for failed reads.
- `rsp_status`, out, 2: 0 = OK, 1 = ERR, 2 = RTY exhausted, 3 = TIMEOUT.
- `wb`, `wb_if.mst`, n/a: Wishbone bus.

## Operation
- States: IDLE, CYCLE, BACKOFF, RESP.
- IDLE:
  - `cmd_ready` = 1; all other outputs are at their idle values.
  - A handshake latches `cmd_we`/`cmd_adr`/`cmd_dat`/`cmd_sel`, clears the retry and timeout counters, and moves to CYCLE.
- CYCLE:
  - `cyc` = `stb` = 1; `we`/`adr`/`sel`/`dat_m2s` are driven from the latched command and held stable for the whole cycle.
  - Responses are sampled each edge with priority `err` > `ack` > `rty`.
  - `ack`: on a read, capture `dat_s2m[DAT_W-1:0]`; set status OK; go to RESP.
  - `err`: set status ERR; `rsp_dat` = 0; go to RESP.
  - `rty` with retry count < `MAX_RETRY`: increment the retry count and go to BACKOFF.
  - `rty` with retry count = `MAX_RETRY`: set status RTY; go to RESP.
  - Timeout counter increments on each edge in CYCLE with no response. When it reaches `TIMEOUT` (and `TIMEOUT` ≠ 0), set status TIMEOUT and go to RESP.
- BACKOFF:
  - `cyc` = `stb` = 0 for `BACKOFF` cycles.
  - Then clear the timeout counter and return to CYCLE with the same latched command.
- RESP:
  - `rsp_valid` = 1; `rsp_dat`/`rsp_status` are held stable.
  - On `rsp_ready`, go to IDLE.
- Outputs tied constant: `cti` = 3'b000 (classic) and `bte` = 2'b00.
- Width rules:
  - `adr`, `dat_m2s` and `sel` are zero-extended to the `WB_*_MAX_WIDTH` widths.
  - Upper bits of `dat_s2m` are ignored.
  - Counter widths are `$clog2(MAX_RETRY+1)` and `$clog2(TIMEOUT+1)`, each at least 1.
- Reset: all bus outputs are registered. Any state returns to IDLE on the next edge, including reset in the middle of a cycle or in RESP.
  - `cyc`/`stb` fall on that edge.
  - The latched command is discarded and no response is produced.
- Reset values:
  - `cmd_ready` = 0 during reset and 1 after the first post-reset edge.
  - `rsp_valid` = 0; `rsp_dat` = 0; `rsp_status` = 0.
  - `cyc` = `stb` = `we` = 0; `adr` = 0; `sel` = 0; `dat_m2s` = 0.

## Timing
- Command handshake at edge N: `cyc`/`stb` are high from N+1.
- Slave response sampled at edge M:
  - `cyc`/`stb` are low from M+1.
  - `rsp_valid` is high from M+1.
- Zero-wait-state slave (`ack` in the first CYCLE cycle): `rsp_valid` rises 2 cycles after the command handshake.
- Minimum command period is 3 cycles (IDLE, CYCLE, RESP); no pipelining or overlap.
- `rty` at edge M: `cyc` is low for exactly `BACKOFF` cycles, then high again at edge M+`BACKOFF`+1.
- Timeout: with no response, `cyc` stays high for exactly `TIMEOUT` cycles.
- A response asserted after `cyc` has dropped is ignored.

## Test plan
- Write 0xA5A5_0001 to 0x10 with sel 0xF, slave acks in the first cycle → one 1-cycle `cyc` pulse; `we` = 1; `adr` = 0x10; response status 0, `rsp_dat` = 0, `rsp_valid` 2 cycles after the handshake.
- Read 0x20 with a 3-wait-state slave returning 0xDEAD_BEEF → `cyc` high for 4 cycles; `rsp_dat` = 0xDEAD_BEEF; status 0.
- Slave always asserts `rty`, `MAX_RETRY`=3, `BACKOFF`=4 → 4 `cyc` pulses, each separated by 4 idle cycles; status 2.
- Slave never responds, `TIMEOUT`=255 → `cyc` high for exactly 255 cycles; status 3. Back-to-back read with `ack` → status 0.
- `err` and `ack` asserted together → status 1, `rsp_dat` = 0. Then hold `rsp_ready` low for 10 cycles → `rsp_valid`/`rsp_status` held stable and `cmd_ready` = 0 throughout.
- Assert `rst` for 1 cycle while in CYCLE → `cyc` low on the next edge; no `rsp_valid`; `cmd_ready` = 1 on the following edge; the next command completes normally.
